// File: rtl/avlstrm_pkt_mux3.sv
// -----------------------------------------------------------------------------
// avlstrm_pkt_mux3
//
// Three-input, packet-atomic Avalon-ST multiplexer. Merges three packet
// streams onto one output without interleaving beats of different packets.
// Arbitration is round-robin between packets; once a packet's first beat is
// accepted, its input owns the output until the eop beat is accepted. The
// output is a single register stage that streams at one beat per cycle,
// including handover between packets from different inputs.
//
// Ports
//   Clk, Rst_n             : clock (rising edge), synchronous active-low reset
//   i_inN_data/sop/eop/empty/valid, o_inN_ready (N = 0..2)
//                          : Avalon-ST sink N
//   o_out_data/sop/eop/empty/valid, i_out_ready
//                          : Avalon-ST source
//
// Input N ready depends combinationally on i_out_ready and every input valid
// (through the arbiter). No path exists from any input valid to o_out_valid.
// -----------------------------------------------------------------------------
module avlstrm_pkt_mux3 #(
  parameter int WIDTH   = 512,
  parameter int EMPTY_W = 6
) (
  input  logic               Clk,
  input  logic               Rst_n,

  input  logic [WIDTH-1:0]   i_in0_data,
  input  logic               i_in0_sop,
  input  logic               i_in0_eop,
  input  logic [EMPTY_W-1:0] i_in0_empty,
  input  logic               i_in0_valid,
  output logic               o_in0_ready,

  input  logic [WIDTH-1:0]   i_in1_data,
  input  logic               i_in1_sop,
  input  logic               i_in1_eop,
  input  logic [EMPTY_W-1:0] i_in1_empty,
  input  logic               i_in1_valid,
  output logic               o_in1_ready,

  input  logic [WIDTH-1:0]   i_in2_data,
  input  logic               i_in2_sop,
  input  logic               i_in2_eop,
  input  logic [EMPTY_W-1:0] i_in2_empty,
  input  logic               i_in2_valid,
  output logic               o_in2_ready,

  output logic [WIDTH-1:0]   o_out_data,
  output logic               o_out_sop,
  output logic               o_out_eop,
  output logic [EMPTY_W-1:0] o_out_empty,
  output logic               o_out_valid,
  input  logic               i_out_ready
);

  // OPEN: free to arbitrate. LOCKED: r_owner holds the output mid-packet.
  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [1:0]   r_owner;
  logic [1:0]   w_owner_nxt;
  logic [1:0]   r_rr_ptr;
  logic [1:0]   w_rr_ptr_nxt;

  logic [WIDTH-1:0]   r_out_data;
  logic               r_out_sop;
  logic               r_out_eop;
  logic [EMPTY_W-1:0] r_out_empty;
  logic               r_out_valid;

  // Bit 3 is a constant zero so a 2-bit index can never select an undefined bit.
  logic [3:0]   w_valid;
  logic [1:0]   w_cand0;
  logic [1:0]   w_cand1;
  logic [1:0]   w_cand2;
  logic         w_gnt_any;
  logic [1:0]   w_gnt_idx;
  logic         w_can_load;
  logic         w_accept;

  logic [WIDTH-1:0]   w_sel_data;
  logic               w_sel_sop;
  logic               w_sel_eop;
  logic [EMPTY_W-1:0] w_sel_empty;
  logic               w_sel_valid;

  // Modulo-3 increment of an input index.
  function automatic logic [1:0] inc_mod3(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  assign w_valid    = {1'b0, i_in2_valid, i_in1_valid, i_in0_valid};
  assign w_cand0    = r_rr_ptr;
  assign w_cand1    = inc_mod3(r_rr_ptr);
  assign w_cand2    = inc_mod3(w_cand1);
  assign w_can_load = !r_out_valid || i_out_ready;

  // Arbiter: locked grants go to the owner even through bubbles; otherwise
  // the first valid input starting at r_rr_ptr wins in the same cycle.
  always_comb begin
    // NOTE: every combinational output is given a default first so no path
    // through the block leaves it unassigned, which would infer a latch.
    w_gnt_any = 1'b0;
    w_gnt_idx = 2'd0;
    if (r_state == ST_LOCKED) begin
      w_gnt_any = 1'b1;
      w_gnt_idx = r_owner;
    end else if (w_valid[w_cand0]) begin
      w_gnt_any = 1'b1;
      w_gnt_idx = w_cand0;
    end else if (w_valid[w_cand1]) begin
      w_gnt_any = 1'b1;
      w_gnt_idx = w_cand1;
    end else if (w_valid[w_cand2]) begin
      w_gnt_any = 1'b1;
      w_gnt_idx = w_cand2;
    end
  end

  // Beat presented by the granted input.
  always_comb begin
    w_sel_data  = i_in0_data;
    w_sel_sop   = i_in0_sop;
    w_sel_eop   = i_in0_eop;
    w_sel_empty = i_in0_empty;
    w_sel_valid = i_in0_valid;
    case (w_gnt_idx)
      2'd1: begin
        w_sel_data  = i_in1_data;
        w_sel_sop   = i_in1_sop;
        w_sel_eop   = i_in1_eop;
        w_sel_empty = i_in1_empty;
        w_sel_valid = i_in1_valid;
      end
      2'd2: begin
        w_sel_data  = i_in2_data;
        w_sel_sop   = i_in2_sop;
        w_sel_eop   = i_in2_eop;
        w_sel_empty = i_in2_empty;
        w_sel_valid = i_in2_valid;
      end
      default: ;
    endcase
  end

  // Ready is held low during reset so no beat is consumed and then lost.
  assign o_in0_ready = Rst_n && w_can_load && w_gnt_any && (w_gnt_idx == 2'd0);
  assign o_in1_ready = Rst_n && w_can_load && w_gnt_any && (w_gnt_idx == 2'd1);
  assign o_in2_ready = Rst_n && w_can_load && w_gnt_any && (w_gnt_idx == 2'd2);

  assign w_accept = Rst_n && w_can_load && w_gnt_any && w_sel_valid;

  // Packet lock next-state: eop releases and rotates priority past the
  // sender; any other beat (sop is not inspected) locks onto the sender.
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    if (w_accept) begin
      if (w_sel_eop) begin
        w_state_nxt  = ST_OPEN;
        w_rr_ptr_nxt = inc_mod3(w_gnt_idx);
      end else begin
        w_state_nxt  = ST_LOCKED;
        w_owner_nxt  = w_gnt_idx;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state  <= ST_OPEN;
      r_owner  <= 2'd0;
      r_rr_ptr <= 2'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // Output register. Refilled on the same edge the old beat leaves, so a
  // continuously ready sink sees one beat per cycle.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      // NOTE: the datapath is cleared as well as valid so the output bus is
      // fully defined after reset; without that only valid would need reset.
      r_out_data  <= '0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_empty <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_data  <= w_sel_data;
      r_out_sop   <= w_sel_sop;
      r_out_eop   <= w_sel_eop;
      r_out_empty <= w_sel_empty;
      r_out_valid <= 1'b1;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_sop   = r_out_sop;
  assign o_out_eop   = r_out_eop;
  assign o_out_empty = r_out_empty;
  assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_avlstrm_pkt_mux3.sv
// -----------------------------------------------------------------------------
// tb_avlstrm_pkt_mux3
//
// Self-checking bench for avlstrm_pkt_mux3. Each scenario queues source beats
// per input and pushes the output order it expects onto a scoreboard; a
// background bus process drives sources on the falling edge, pops and
// compares every output transfer, and checks latency, stall and reset
// behaviour as they occur.
// -----------------------------------------------------------------------------
module tb_avlstrm_pkt_mux3;

  localparam int WIDTH   = 512;
  localparam int EMPTY_W = 6;

  typedef struct packed {
    logic [WIDTH-1:0]   data;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
  } beat_t;

  logic               Clk = 1'b0;
  logic               Rst_n = 1'b0;
  logic [WIDTH-1:0]   in_data  [3];
  logic               in_sop   [3];
  logic               in_eop   [3];
  logic [EMPTY_W-1:0] in_empty [3];
  logic               in_valid [3];
  logic               in_ready [3];
  logic [WIDTH-1:0]   o_out_data;
  logic               o_out_sop;
  logic               o_out_eop;
  logic [EMPTY_W-1:0] o_out_empty;
  logic               o_out_valid;
  logic               out_ready;

  avlstrm_pkt_mux3 #(.WIDTH(WIDTH), .EMPTY_W(EMPTY_W)) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .i_in0_data  (in_data[0]),  .i_in0_sop (in_sop[0]), .i_in0_eop (in_eop[0]),
    .i_in0_empty (in_empty[0]), .i_in0_valid(in_valid[0]), .o_in0_ready(in_ready[0]),
    .i_in1_data  (in_data[1]),  .i_in1_sop (in_sop[1]), .i_in1_eop (in_eop[1]),
    .i_in1_empty (in_empty[1]), .i_in1_valid(in_valid[1]), .o_in1_ready(in_ready[1]),
    .i_in2_data  (in_data[2]),  .i_in2_sop (in_sop[2]), .i_in2_eop (in_eop[2]),
    .i_in2_empty (in_empty[2]), .i_in2_valid(in_valid[2]), .o_in2_ready(in_ready[2]),
    .o_out_data  (o_out_data),
    .o_out_sop   (o_out_sop),
    .o_out_eop   (o_out_eop),
    .o_out_empty (o_out_empty),
    .o_out_valid (o_out_valid),
    .i_out_ready (out_ready)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  beat_t in_q [3][$];
  beat_t exp_q[$];
  int    out_cyc_q[$];

  int               cyc = 0;
  int               rst_cycles = 0;
  int               stall_left = 0;
  bit               stall_armed = 0;
  logic [WIDTH-1:0] stall_on = '0;
  bit               rst_armed = 0;
  logic [WIDTH-1:0] rst_on = '0;
  bit               abandon2 = 0;
  bit               chk_after_rst = 0;
  beat_t            last_acc;
  bit               last_acc_v = 0;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] id, input logic sop,
                               input logic eop, input logic [EMPTY_W-1:0] empty);
    beat_t b;
    b.data  = {16{id}};
    b.sop   = sop;
    b.eop   = eop;
    b.empty = empty;
    return b;
  endfunction

  // Queue an n-beat packet on input src and append it to the expected order.
  task automatic send_pkt(input int src, input logic [31:0] base, input int n,
                          input logic [EMPTY_W-1:0] empty, input bit expect_it);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b = mk(base + i, i == 0, i == n - 1, (i == n - 1) ? empty : '0);
      in_q[src].push_back(b);
      if (expect_it) exp_q.push_back(b);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge Clk);
    #2;
  endtask

  task automatic wait_idle(input string tag);
    int budget;
    budget = 300;
    while ((in_q[0].size() + in_q[1].size() + in_q[2].size() + exp_q.size()) != 0
           && budget > 0) begin
      wait_cycles(1);
      budget--;
    end
    check({tag, "_drained"}, budget > 0, 1);
    for (int n = 0; n < 3; n++) in_q[n].delete();
    exp_q.delete();
    wait_cycles(2);
  endtask

  task automatic check_span(input string tag, input int beats);
    check({tag, "_beats"}, out_cyc_q.size(), beats);
    if (out_cyc_q.size() == beats)
      check({tag, "_back2back"}, out_cyc_q[beats-1] - out_cyc_q[0], beats - 1);
  endtask

  // Bus process: all driving and sampling happens around the falling edge.
  initial begin
    for (int n = 0; n < 3; n++) begin
      in_data[n] = '0; in_sop[n] = 1'b0; in_eop[n] = 1'b0;
      in_empty[n] = '0; in_valid[n] = 1'b0;
    end
    out_ready = 1'b1;
    forever begin
      @(negedge Clk);
      cyc++;
      if (chk_after_rst) begin
        chk_after_rst = 0;
        check("rst_mid_out_valid", o_out_valid, 0);
        check("rst_mid_out_data", o_out_data, 0);
      end
      if (last_acc_v) begin
        last_acc_v = 0;
        check("latency_valid", o_out_valid, 1);
        check("latency_data", o_out_data, last_acc.data);
      end
      if (abandon2) begin
        abandon2 = 0;
        in_q[2].delete();
      end
      if (stall_armed && o_out_valid === 1'b1 && o_out_data === stall_on) begin
        stall_armed = 0;
        stall_left  = 3;
      end
      if (rst_armed && o_out_valid === 1'b1 && o_out_data === rst_on) begin
        rst_armed     = 0;
        rst_cycles    = 1;
        abandon2      = 1;
        chk_after_rst = 1;
      end
      Rst_n = (rst_cycles == 0);
      if (rst_cycles > 0) rst_cycles--;
      out_ready = (stall_left == 0);
      for (int n = 0; n < 3; n++) begin
        if (in_q[n].size() > 0) begin
          in_valid[n] = 1'b1;
          in_data[n]  = in_q[n][0].data;
          in_sop[n]   = in_q[n][0].sop;
          in_eop[n]   = in_q[n][0].eop;
          in_empty[n] = in_q[n][0].empty;
        end else begin
          in_valid[n] = 1'b0;
        end
      end
      #1;
      if (!Rst_n)
        for (int n = 0; n < 3; n++) check("rst_ready_low", in_ready[n], 0);
      if (stall_left > 0) begin
        stall_left--;
        check("stall_valid", o_out_valid, 1);
        check("stall_data", o_out_data, stall_on);
        for (int n = 0; n < 3; n++) check("stall_ready_low", in_ready[n], 0);
      end
      if (o_out_valid === 1'b1 && out_ready) begin
        out_cyc_q.push_back(cyc);
        check("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          beat_t e;
          e = exp_q.pop_front();
          check("out_data", o_out_data, e.data);
          check("out_sop", o_out_sop, e.sop);
          check("out_eop", o_out_eop, e.eop);
          check("out_empty", o_out_empty, e.empty);
        end
      end
      for (int n = 0; n < 3; n++) begin
        if (in_valid[n] && in_ready[n] === 1'b1 && in_q[n].size() > 0) begin
          last_acc   = in_q[n].pop_front();
          last_acc_v = 1;
        end
      end
    end
  end

  initial begin
    // Reset state.
    rst_cycles = 2;
    wait_cycles(4);
    check("reset_out_valid", o_out_valid, 0);
    check("reset_out_sop", o_out_sop, 0);
    check("reset_out_data", o_out_data, 0);

    // 3-beat packet on in1, empty=5 on eop; latency checked by the bus process.
    out_cyc_q.delete();
    send_pkt(1, 32'h0000_1000, 3, 6'd5, 1);
    wait_idle("t1");
    check_span("t1", 3);

    // rr_ptr must now be 2: simultaneous single beats leave as in2, in0, in1.
    in_q[0].push_back(mk(32'h10, 1, 1, 6'd1));
    in_q[1].push_back(mk(32'h11, 1, 1, 6'd2));
    in_q[2].push_back(mk(32'h12, 1, 1, 6'd3));
    exp_q.push_back(mk(32'h12, 1, 1, 6'd3));
    exp_q.push_back(mk(32'h10, 1, 1, 6'd1));
    exp_q.push_back(mk(32'h11, 1, 1, 6'd2));
    wait_idle("t1_rr");

    // After reset, three 2-beat packets at once: A, B, C back-to-back.
    rst_cycles = 1;
    wait_cycles(2);
    out_cyc_q.delete();
    send_pkt(0, 32'hA000, 2, 6'd0, 1);
    send_pkt(1, 32'hB000, 2, 6'd7, 1);
    send_pkt(2, 32'hC000, 2, 6'd9, 1);
    wait_idle("t2");
    check_span("t2", 6);

    // in0 streams two 4-beat packets while in2 waits: P1, Q, P2.
    out_cyc_q.delete();
    send_pkt(0, 32'hD100, 4, 6'd2, 0);
    send_pkt(0, 32'hD200, 4, 6'd4, 0);
    send_pkt(2, 32'hE100, 3, 6'd6, 0);
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(32'hD100 + i, i == 0, i == 3, (i == 3) ? 6'd2 : 6'd0));
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(32'hE100 + i, i == 0, i == 2, (i == 2) ? 6'd6 : 6'd0));
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(32'hD200 + i, i == 0, i == 3, (i == 3) ? 6'd4 : 6'd0));
    wait_idle("t3");
    check_span("t3", 11);

    // Backpressure for 3 cycles while beat 2 of an in1 packet is on the output;
    // in0 also waits so blocked readies are exercised on two inputs.
    stall_on    = mk(32'hF001, 0, 0, 6'd0).data;
    stall_armed = 1;
    send_pkt(1, 32'hF000, 4, 6'd3, 1);
    send_pkt(0, 32'hF100, 1, 6'd8, 1);
    wait_idle("t4");
    check("t4_stall_seen", stall_armed, 0);

    // Single-beat packets everywhere: strict rotation in0, in1, in2.
    rst_cycles = 1;
    wait_cycles(2);
    out_cyc_q.delete();
    for (int r = 0; r < 3; r++)
      for (int n = 0; n < 3; n++) in_q[n].push_back(mk(32'h5000 + 16 * n + r, 1, 1, 6'(n)));
    for (int r = 0; r < 3; r++)
      for (int n = 0; n < 3; n++) exp_q.push_back(mk(32'h5000 + 16 * n + r, 1, 1, 6'(n)));
    wait_idle("t5");
    check_span("t5", 9);

    // Reset right after beat 1 of an in2 packet: packet abandoned, lock freed.
    rst_on    = mk(32'h7000, 1, 0, 6'd0).data;
    rst_armed = 1;
    send_pkt(2, 32'h7000, 3, 6'd1, 0);
    exp_q.push_back(mk(32'h7000, 1, 0, 6'd0));
    wait_idle("t6_abandon");
    check("t6_reset_seen", rst_armed, 0);
    send_pkt(0, 32'h7100, 2, 6'd5, 1);
    wait_idle("t6_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
